// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: exception code defaults
// and the occupancy encoding used by the skid register.
package pipe_pkg;

    localparam int EXC_W_DEFAULT = 5;
    localparam int EXC_NONE      = 0;

    // Encoding equals the number of held entries, so it doubles as Occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One stage-register slot (Data/BD/PC/Exc) with synchronous clear and load.
// Clear wins over load.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int EXC_W  = EXC_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic [31:0]       in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    output logic [DATA_W-1:0] data,
    output logic              bd,
    output logic [31:0]       pc,
    output logic [EXC_W-1:0]  exc
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              bd_q, bd_d;
    logic [31:0]       pc_q, pc_d;
    logic [EXC_W-1:0]  exc_q, exc_d;

    always_comb begin
        data_d = data_q;
        bd_d   = bd_q;
        pc_d   = pc_q;
        exc_d  = exc_q;
        if (clear) begin
            data_d = '0;
            bd_d   = 1'b0;
            pc_d   = '0;
            exc_d  = '0;
        end else if (load) begin
            data_d = in_data;
            bd_d   = in_bd;
            pc_d   = in_pc;
            exc_d  = in_exc;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q <= '0;
            bd_q   <= 1'b0;
            pc_q   <= '0;
            exc_q  <= '0;
        end else begin
            data_q <= data_d;
            bd_q   <= bd_d;
            pc_q   <= pc_d;
            exc_q  <= exc_d;
        end
    end

    assign data = data_q;
    assign bd   = bd_q;
    assign pc   = pc_q;
    assign exc  = exc_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid stage register between pipeline stages. InReady/OutValid
// come straight from the state flop, so OutReady never reaches InReady.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int EXC_W  = EXC_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic              InBD,
    input  logic [31:0]       InPC,
    input  logic [EXC_W-1:0]  InExc,
    input  logic [EXC_W-1:0]  LocalExc,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic              OutBD,
    output logic [31:0]       OutPC,
    output logic [EXC_W-1:0]  OutExc,
    output logic [1:0]        Occupancy
);

    localparam logic [EXC_W-1:0] EXC_ZERO = EXC_W'(EXC_NONE);

    occ_state_e state_q, state_d;

    logic in_ready, out_valid, accept, pop;
    logic main_load, main_from_skid, skid_load;

    logic [EXC_W-1:0]  wr_exc;
    logic [DATA_W-1:0] main_in_data, main_data, skid_data;
    logic              main_in_bd, main_bd, skid_bd;
    logic [31:0]       main_in_pc, main_pc, skid_pc;
    logic [EXC_W-1:0]  main_in_exc, main_exc, skid_exc;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = InValid && in_ready;
    assign pop       = out_valid && OutReady;

    // An exception raised by an earlier stage takes priority over our own.
    assign wr_exc = (InExc != EXC_ZERO) ? InExc : LocalExc;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!Flush) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (!accept && pop) begin
                        state_d = ST_EMPTY;
                    end else if (accept && pop) begin
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        main_in_data = InData;
        main_in_bd   = InBD;
        main_in_pc   = InPC;
        main_in_exc  = wr_exc;
        if (main_from_skid) begin
            main_in_data = skid_data;
            main_in_bd   = skid_bd;
            main_in_pc   = skid_pc;
            main_in_exc  = skid_exc;
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (Flush),
        .load    (main_load),
        .in_data (main_in_data),
        .in_bd   (main_in_bd),
        .in_pc   (main_in_pc),
        .in_exc  (main_in_exc),
        .data    (main_data),
        .bd      (main_bd),
        .pc      (main_pc),
        .exc     (main_exc)
    );

    pipe_entry #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (Flush),
        .load    (skid_load),
        .in_data (InData),
        .in_bd   (InBD),
        .in_pc   (InPC),
        .in_exc  (wr_exc),
        .data    (skid_data),
        .bd      (skid_bd),
        .pc      (skid_pc),
        .exc     (skid_exc)
    );

    // main is not cleared on a plain pop, so bubble fields are gated here.
    assign InReady   = in_ready;
    assign OutValid  = out_valid;
    assign OutData   = out_valid ? main_data : '0;
    assign OutBD     = out_valid ? main_bd   : 1'b0;
    assign OutPC     = out_valid ? main_pc   : '0;
    assign OutExc    = out_valid ? main_exc  : '0;
    assign Occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: single pass, backpressure, streaming,
// flush collisions, exception priority and asynchronous reset.
module tb_pipe_skid_reg;

    localparam int DATA_W = 160;
    localparam int EXC_W  = 5;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] InData;
    logic              InBD;
    logic [31:0]       InPC;
    logic [EXC_W-1:0]  InExc;
    logic [EXC_W-1:0]  LocalExc;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutData;
    logic              OutBD;
    logic [31:0]       OutPC;
    logic [EXC_W-1:0]  OutExc;
    logic [1:0]        Occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Flush     (Flush),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .InBD      (InBD),
        .InPC      (InPC),
        .InExc     (InExc),
        .LocalExc  (LocalExc),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutBD     (OutBD),
        .OutPC     (OutPC),
        .OutExc    (OutExc),
        .Occupancy (Occupancy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] pc,
                         input logic [EXC_W-1:0] iexc, input logic [EXC_W-1:0] lexc);
        InValid  = v;
        InPC     = pc;
        InData   = {5{pc}};
        InBD     = pc[2];
        InExc    = iexc;
        LocalExc = lexc;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_occ"},   64'(Occupancy), 64'd0);
        chk({tag, "_valid"}, 64'(OutValid),  64'd0);
        chk({tag, "_ready"}, 64'(InReady),   64'd1);
        chk({tag, "_pc"},    64'(OutPC),     64'd0);
        chk({tag, "_bd"},    64'(OutBD),     64'd0);
        chk({tag, "_exc"},   64'(OutExc),    64'd0);
        chk_data({tag, "_data"}, OutData, '0);
    endtask

    initial begin
        Reset_n  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b0;
        offer(1'b0, 32'h0, '0, '0);
        #3;
        chk_bubble("reset");
        tick();
        Reset_n = 1'b1;

        // Single pass with local exception.
        offer(1'b1, 32'h3000, 5'd0, 5'd4);
        tick();
        offer(1'b0, 32'h0, '0, '0);
        chk("single_valid", 64'(OutValid),  64'd1);
        chk("single_pc",    64'(OutPC),     64'h3000);
        chk("single_exc",   64'(OutExc),    64'd4);
        chk("single_occ",   64'(Occupancy), 64'd1);
        chk("single_bd",    64'(OutBD),     64'd0);
        chk_data("single_data", OutData, {5{32'h3000}});
        OutReady = 1'b1;
        tick();
        chk_bubble("single_drain");

        // Backpressure: A, B fill; C waits.
        OutReady = 1'b0;
        offer(1'b1, 32'h3000, '0, '0);
        tick();
        chk("bp_occ_a", 64'(Occupancy), 64'd1);
        offer(1'b1, 32'h3004, '0, '0);
        tick();
        chk("bp_occ_ab",   64'(Occupancy), 64'd2);
        chk("bp_ready_ab", 64'(InReady),   64'd0);
        chk("bp_pc_ab",    64'(OutPC),     64'h3000);
        offer(1'b1, 32'h3008, '0, '0);
        tick();
        chk("bp_occ_hold", 64'(Occupancy), 64'd2);
        chk("bp_pc_hold",  64'(OutPC),     64'h3000);
        OutReady = 1'b1;
        tick();
        chk("bp_pc_b",    64'(OutPC),     64'h3004);
        chk("bp_bd_b",    64'(OutBD),     64'd1);
        chk("bp_occ_b",   64'(Occupancy), 64'd1);
        chk("bp_ready_b", 64'(InReady),   64'd1);
        tick();
        offer(1'b0, 32'h0, '0, '0);
        chk("bp_pc_c",  64'(OutPC),     64'h3008);
        chk("bp_occ_c", 64'(Occupancy), 64'd1);
        tick();
        chk("bp_occ_end", 64'(Occupancy), 64'd0);

        // Streaming at one entry per cycle.
        OutReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'h3000 + 32'(4 * i), '0, '0);
            tick();
            chk("stream_pc",    64'(OutPC),     64'(32'h3000 + 32'(4 * i)));
            chk("stream_occ",   64'(Occupancy), 64'd1);
            chk("stream_valid", 64'(OutValid),  64'd1);
        end
        offer(1'b0, 32'h0, '0, '0);
        tick();
        chk("stream_occ_end", 64'(Occupancy), 64'd0);

        // Flush while FULL, colliding with offer and pop.
        OutReady = 1'b0;
        offer(1'b1, 32'h3100, 5'd3, 5'd0);
        tick();
        offer(1'b1, 32'h3104, 5'd0, 5'd2);
        tick();
        chk("flush_full_occ", 64'(Occupancy), 64'd2);
        Flush    = 1'b1;
        OutReady = 1'b1;
        offer(1'b1, 32'h3108, 5'd1, 5'd1);
        tick();
        Flush = 1'b0;
        offer(1'b0, 32'h0, '0, '0);
        chk_bubble("flush_full");
        tick();
        chk_bubble("flush_full_after");

        // Flush while ONE: entry offered with InReady high is dropped.
        OutReady = 1'b0;
        offer(1'b1, 32'h3200, '0, '0);
        tick();
        chk("flush_one_occ", 64'(Occupancy), 64'd1);
        Flush = 1'b1;
        offer(1'b1, 32'h3204, '0, '0);
        tick();
        Flush = 1'b0;
        offer(1'b0, 32'h0, '0, '0);
        chk_bubble("flush_one");

        // Exception priority, including through the skid slot.
        offer(1'b1, 32'h3300, 5'd10, 5'd4);
        tick();
        chk("exc_in_prio", 64'(OutExc), 64'd10);
        OutReady = 1'b1;
        offer(1'b1, 32'h3304, 5'd0, 5'd0);
        tick();
        chk("exc_none",    64'(OutExc), 64'd0);
        chk("exc_none_pc", 64'(OutPC),  64'h3304);
        OutReady = 1'b0;
        offer(1'b1, 32'h3308, 5'd0, 5'd7);
        tick();
        chk("exc_skid_occ", 64'(Occupancy), 64'd2);
        OutReady = 1'b1;
        offer(1'b0, 32'h0, '0, '0);
        tick();
        chk("exc_skid_val", 64'(OutExc), 64'd7);
        chk("exc_skid_pc",  64'(OutPC),  64'h3308);
        tick();
        chk("exc_occ_end", 64'(Occupancy), 64'd0);

        // Asynchronous reset between clock edges while FULL.
        OutReady = 1'b0;
        offer(1'b1, 32'h3400, 5'd5, 5'd0);
        tick();
        offer(1'b1, 32'h3404, 5'd0, 5'd0);
        tick();
        offer(1'b0, 32'h0, '0, '0);
        chk("areset_full_occ", 64'(Occupancy), 64'd2);
        #2;
        Reset_n = 1'b0;
        #2;
        chk_bubble("areset");
        #2;
        Reset_n = 1'b1;
        offer(1'b1, 32'h3500, '0, '0);
        tick();
        offer(1'b0, 32'h0, '0, '0);
        chk("areset_after_occ", 64'(Occupancy), 64'd1);
        chk("areset_after_pc",  64'(OutPC),     64'h3500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160: width of the opaque stage payload (instruction, operands, immediate, A3, WD).
REQ-002 SHALL have parameter EXC_W, default 5: width of the exception code.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port Flush, input, 1: synchronous discard of all held entries.
REQ-006 SHALL have port InValid, input, 1: upstream offers an entry.
REQ-007 SHALL have port InReady, output, 1: block accepts an entry this cycle.
REQ-008 SHALL have ports InData (DATA_W), InBD (1), InPC (32) and InExc (EXC_W), all inputs: upstream entry fields.
REQ-009 SHALL have port LocalExc, input, EXC_W: exception detected by the upstream stage itself.
REQ-010 SHALL have port OutValid, output, 1: head entry present.
REQ-011 SHALL have port OutReady, input, 1: downstream accepts the head entry.
REQ-012 SHALL have ports OutData (DATA_W), OutBD (1), OutPC (32) and OutExc (EXC_W), all outputs: head entry fields.
REQ-013 SHALL have port Occupancy, output, 2: number of held entries (0, 1 or 2).

Function
REQ-014 SHALL hold two entries, main and skid; the state is EMPTY (0), ONE (1) or FULL (2), and Occupancy SHALL equal the state.
REQ-015 SHALL drive InReady = (state != FULL) and OutValid = (state != EMPTY), both decoded from registers only, with no combinational path from OutReady.
REQ-016 Accept SHALL be InValid && InReady; pop SHALL be OutValid && OutReady.
REQ-017 Transitions, state update only:
- EMPTY: accept -> ONE, main <= input.
- ONE: accept only -> FULL, skid <= input.
- ONE: pop only -> EMPTY.
- ONE: accept and pop -> ONE, main <= input.
- FULL: pop -> ONE, main <= skid.
- FULL: no pop -> FULL, hold.
REQ-018 The Out* fields SHALL always present main; when EMPTY, all Out* fields SHALL be 0, so the downstream stage sees an all-zero bubble.
REQ-019 On every write of an entry, stored Exc SHALL be InExc when InExc != 0, else LocalExc; an earlier-stage exception has priority.
REQ-020 InBD, InPC and InData SHALL be stored unmodified, including when an exception code is attached.
REQ-021 Latency SHALL be 1 cycle from accept to OutValid when EMPTY; sustained throughput SHALL be 1 entry/cycle when OutReady is held high.
REQ-022 Flush SHALL have top priority: the next state is EMPTY and main and skid are cleared to 0, regardless of accept or pop in the same cycle.
REQ-023 An entry offered in a Flush cycle SHALL be discarded, even though InReady was high.
REQ-024 Entry order SHALL be preserved: no entry is lost, duplicated or reordered without Flush.

Reset
REQ-025 Reset_n low SHALL force, immediately and independent of Clk, state EMPTY and main and skid all 0. As a result: InReady=1, OutValid=0, all Out*=0, Occupancy=0.
REQ-026 Reset asserted mid-transfer SHALL drop all held entries; the first accept after Reset_n deasserts SHALL behave as from EMPTY.

Structure
REQ-027 A shared package pipe_pkg SHALL hold: EXC_W default, EXC_NONE=0, and the occupancy state encoding (EMPTY/ONE/FULL).
REQ-028 SHALL instantiate a sub-module pipe_entry twice (main and skid): one register slot holding Data/BD/PC/Exc, with load, clear and async reset.

Verification
REQ-029 Bench SHALL cover single pass: EMPTY, InValid=1 with InPC=0x3000, InExc=0, LocalExc=4 -> next cycle OutValid=1, OutPC=0x3000, OutExc=4, Occupancy=1.
REQ-030 Bench SHALL cover backpressure: OutReady=0, accept A (PC 0x3000) then B (PC 0x3004) -> Occupancy=2, InReady=0; C held at input is not taken; OutReady=1 -> A out, then B out, then C accepted.
REQ-031 Bench SHALL cover streaming: OutReady=1 with 8 back-to-back entries PC 0x3000..0x301C -> outputs in order, one per cycle, 1-cycle lag, Occupancy never 2.
REQ-032 Bench SHALL cover flush collision: FULL, then Flush=1 together with InValid=1 and OutReady=1 -> next cycle Occupancy=0, all Out*=0; the offered entry never appears.
REQ-033 Bench SHALL cover exception priority: InExc=10 with LocalExc=4 -> OutExc=10; InExc=0 with LocalExc=0 -> OutExc=0.
REQ-034 Bench SHALL cover async reset: Reset_n pulsed low between clock edges while FULL -> outputs zero before the next edge; after release, one accept gives Occupancy=1.
